// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
// Shared definitions for the d16 prefetch queue.
//   fq_state_t  : fetch FSM states (FQ_IDLE, FQ_FETCH, FQ_DROP)
//   fq_ext_bit  : index of the "two-word instruction" flag within a word
package fetch_queue_pkg;

    typedef enum logic [1:0] {
        FQ_IDLE  = 2'd0,  // no request outstanding
        FQ_FETCH = 2'd1,  // request outstanding, response will be queued
        FQ_DROP  = 2'd2   // request outstanding, response will be discarded
    } fq_state_t;

    // The extension flag lives in the MSB of the first instruction word.
    function automatic int fq_ext_bit(input int data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo
// Circular buffer of {pc, word} pairs feeding the decode stage.
//   clk, rst              : clock, synchronous active-high reset
//   push, push_pc/word    : append one entry at the tail
//   pop1 / pop2           : remove one / two entries from the head
//   clear                 : empty the buffer (wins over push/pop)
//   head_pc, head_word    : entry at the head
//   next_word             : word at head+1 (extension word of a pair)
//   count                 : number of valid entries (0..DEPTH)
module fetch_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_pc,
    input  logic [DATA_W-1:0]            push_word,
    input  logic                         pop1,
    input  logic                         pop2,
    input  logic                         clear,
    output logic [ADDR_W-1:0]            head_pc,
    output logic [DATA_W-1:0]            head_word,
    output logic [DATA_W-1:0]            next_word,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] word_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [CNT_W-1:0] pop_cnt;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pop_cnt  = '0;
        if (pop2) begin
            pop_cnt = CNT_W'(2);
        end else if (pop1) begin
            pop_cnt = CNT_W'(1);
        end
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop2) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(2);
            end else if (pop1) begin
                rd_ptr_d = rd_ptr_p1;
            end
            count_d = count_q + CNT_W'(push) - pop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            pc_mem[wr_ptr_q]   <= push_pc;
            word_mem[wr_ptr_q] <= push_word;
        end
    end

    assign head_pc   = pc_mem[rd_ptr_q];
    assign head_word = word_mem[rd_ptr_q];
    assign next_word = word_mem[rd_ptr_p1];
    assign count     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
// Decoupled instruction fetcher with a DEPTH-word prefetch queue.
//   clk, rst            : clock, synchronous active-high reset
//   mem_req/mem_addr    : fetch request, held with a stable address until mem_ready
//   mem_ready/mem_rdata : response strobe and fetched word
//   branch_valid/target : redirect; flushes the queue and restarts fetch at target
//   instr_valid/instr/instr_ext/instr_pc : head instruction to decode
//   instr_ready         : decode accepts the head instruction
//   level               : number of words currently queued
// Build option: define FETCH_QUEUE_PAIR_EN to present two-word instructions
// (MSB of the first word set) as a single {instr, instr_ext} pair.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        mem_ready,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        branch_valid,
    input  logic [ADDR_W-1:0]           branch_target,
    output logic                        instr_valid,
    output logic [DATA_W-1:0]           instr,
    output logic [DATA_W-1:0]           instr_ext,
    output logic [ADDR_W-1:0]           instr_pc,
    input  logic                        instr_ready,
    output logic [$clog2(DEPTH+1)-1:0]  level
);

    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int EXT_BIT = fq_ext_bit(DATA_W);
`ifdef FETCH_QUEUE_PAIR_EN
    localparam bit PAIR_EN = 1'b1;
`else
    localparam bit PAIR_EN = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] EVEN_MASK = ~ADDR_W'(1);
    localparam logic [CNT_W:0]    DEPTH_W   = (CNT_W+1)'(DEPTH);

    fq_state_t         state_q, state_d;
    logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;

    logic              push, clear, pop1, pop2, pop_fire, head_ext;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_word, next_word;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    pop_words, level_after_pop;

    fetch_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_pc   (fetch_ptr_q),
        .push_word (mem_rdata),
        .pop1      (pop1),
        .pop2      (pop2),
        .clear     (clear),
        .head_pc   (head_pc),
        .head_word (head_word),
        .next_word (next_word),
        .count     (count)
    );

    // Head presentation is decoded purely from queue state.
    assign head_ext    = PAIR_EN && head_word[EXT_BIT];
    assign instr_valid = (count != '0) && (!head_ext || count >= CNT_W'(2));
    assign instr       = instr_valid ? head_word : '0;
    assign instr_ext   = (instr_valid && head_ext) ? next_word : '0;
    assign instr_pc    = instr_valid ? head_pc : '0;
    assign level       = count;

    // mem_req depends on the state register only, never on instr_ready.
    assign mem_req  = (state_q != FQ_IDLE);
    // While dropping, keep presenting the abandoned address so the pending
    // request stays stable; fetch_ptr_q already holds the redirect target.
    assign mem_addr = (state_q == FQ_DROP) ? drop_addr_q : fetch_ptr_q;

    // A redirect suppresses the pop in the same cycle.
    assign pop_fire = instr_valid && instr_ready && !branch_valid;
    assign pop2     = pop_fire && head_ext;
    assign pop1     = pop_fire && !head_ext;

    always_comb begin
        pop_words = '0;
        if (pop2) begin
            pop_words = (CNT_W+1)'(2);
        end else if (pop1) begin
            pop_words = (CNT_W+1)'(1);
        end
        level_after_pop = {1'b0, count} - pop_words;
    end

    always_comb begin
        state_d     = state_q;
        fetch_ptr_d = fetch_ptr_q;
        drop_addr_d = drop_addr_q;
        push        = 1'b0;
        clear       = 1'b0;
        if (branch_valid) begin
            clear       = 1'b1;
            fetch_ptr_d = branch_target & EVEN_MASK;
            case (state_q)
                FQ_FETCH: begin
                    if (mem_ready) begin
                        state_d = FQ_FETCH;
                    end else begin
                        state_d     = FQ_DROP;
                        drop_addr_d = fetch_ptr_q;
                    end
                end
                FQ_DROP:  state_d = mem_ready ? FQ_FETCH : FQ_DROP;
                default:  state_d = FQ_FETCH;
            endcase
        end else begin
            case (state_q)
                FQ_IDLE: begin
                    if (level_after_pop < DEPTH_W) begin
                        state_d = FQ_FETCH;
                    end
                end
                FQ_FETCH: begin
                    if (mem_ready) begin
                        push        = 1'b1;
                        fetch_ptr_d = fetch_ptr_q + ADDR_W'(2);
                        // The next request must still find a free slot
                        // once this word has landed.
                        state_d = (level_after_pop + (CNT_W+1)'(1) < DEPTH_W)
                                  ? FQ_FETCH : FQ_IDLE;
                    end
                end
                FQ_DROP: begin
                    if (mem_ready) begin
                        state_d = FQ_FETCH;
                    end
                end
                default: state_d = FQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FQ_IDLE;
            fetch_ptr_q <= RESET_PC & EVEN_MASK;
            drop_addr_q <= RESET_PC & EVEN_MASK;
        end else begin
            state_q     <= state_d;
            fetch_ptr_q <= fetch_ptr_d;
            drop_addr_q <= drop_addr_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Self-checking bench for fetch_queue: directed reset/fill/pop/redirect/wrap
// scenarios followed by a randomized run. The reference model tracks only the
// architectural program counter of the next instruction the decoder should see
// and reads the expected words from a bench-side memory image.
module tb_fetch_queue;

    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_PAIR_EN
    localparam bit PAIR = 1'b1;
`else
    localparam bit PAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        branch_valid;
    logic [15:0] branch_target;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_ext;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  level;

    fetch_queue #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .DEPTH    (DEPTH),
        .RESET_PC (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ext     (instr_ext),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .level         (level)
    );

    always #5 clk = ~clk;

    logic [15:0] img [0:32767];

    int          vectors    = 0;
    int          miscompares = 0;
    int          pops       = 0;
    logic [15:0] exp_pc;
    bit          pend;
    bit          prev_br;
    logic [15:0] prev_addr;
    int          wait_left;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        mem_ready     = 1'b0;
        mem_rdata     = 16'h0;
        instr_ready   = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_pc    = 16'h0000;
        pend      = 1'b0;
        prev_br   = 1'b0;
        prev_addr = 16'h0;
        wait_left = 0;
    endtask

    // One clock cycle. Called 1 time unit after a rising edge.
    // mode: 0 zero-wait memory, 1 stalled memory, 2 random 0-3 waits, 3 fixed 3 waits
    task automatic step(input bit rd, input bit br, input logic [15:0] tgt, input int mode);
        logic [15:0] ew, ee, nxt;
        chk("level_le_depth", 32'(int'(level) <= DEPTH), 32'd1);
        if (mem_req) chk("addr_even", 32'(mem_addr[0]), 32'd0);
        if (pend) begin
            chk("req_held", 32'(mem_req), 32'd1);
            chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
        end
        if (prev_br) chk("valid_after_br", 32'(instr_valid), 32'd0);

        mem_ready = 1'b0;
        mem_rdata = 16'($urandom);
        if (mem_req) begin
            if (!pend) wait_left = (mode == 2) ? int'($urandom_range(0, 3)) : (mode == 3) ? 3 : 0;
            if (mode != 1) begin
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = img[mem_addr[15:1]];
                end else begin
                    wait_left--;
                end
            end
        end
        instr_ready   = rd;
        branch_valid  = br;
        branch_target = tgt;

        if (!br && instr_valid && rd) begin
            ew  = img[exp_pc[15:1]];
            nxt = exp_pc + 16'd2;
            ee  = (PAIR && ew[15]) ? img[nxt[15:1]] : 16'h0;
            chk("instr_pc", 32'(instr_pc), 32'(exp_pc));
            chk("instr", 32'(instr), 32'(ew));
            chk("instr_ext", 32'(instr_ext), 32'(ee));
            $display("pop pc=%h instr=%h ext=%h level=%0d", instr_pc, instr, instr_ext, level);
            exp_pc = exp_pc + ((PAIR && ew[15]) ? 16'd4 : 16'd2);
            pops++;
        end
        if (br) exp_pc = tgt & 16'hFFFE;

        pend      = mem_req && !mem_ready;
        prev_addr = mem_addr;
        prev_br   = br;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pops_start;
        logic [15:0] w;
        for (int i = 0; i < 32768; i++) begin
            w     = 16'($urandom);
            w[15] = ($urandom_range(0, 99) < 30);
            img[i] = w;
        end
        img[0]      = 16'h1234;
        img[1]      = 16'h8101;
        img[2]      = 16'h00AA;
        img[32767]  = 16'h8155;

        // Reset values
        do_reset();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_ext", 32'(instr_ext), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);

        // First fetch and latency
        step(1'b0, 1'b0, 16'h0, 0);
        chk("req_cycle1", 32'(mem_req), 32'd1);
        chk("addr_cycle1", 32'(mem_addr), 32'h0000);
        step(1'b0, 1'b0, 16'h0, 0);
        chk("valid_cycle2", 32'(instr_valid), 32'd1);
        chk("instr_cycle2", 32'(instr), 32'h1234);
        chk("pc_cycle2", 32'(instr_pc), 32'h0000);

        // Fill until full; fetch must stop
        for (int i = 0; i < 20 && level != 3'd4; i++) step(1'b0, 1'b0, 16'h0, 0);
        chk("level_full", 32'(level), 32'd4);
        step(1'b0, 1'b0, 16'h0, 0);
        step(1'b0, 1'b0, 16'h0, 0);
        chk("req_when_full", 32'(mem_req), 32'd0);
        chk("level_hold", 32'(level), 32'd4);

        // Pops with memory stalled so level moves only by pops
        step(1'b1, 1'b0, 16'h0, 1);
        chk("level_pop1", 32'(level), 32'd3);
        chk("pair_head", 32'(instr), 32'h8101);
        chk("pair_head_pc", 32'(instr_pc), 32'h0002);
`ifdef FETCH_QUEUE_PAIR_EN
        chk("pair_ext", 32'(instr_ext), 32'h00AA);
        step(1'b1, 1'b0, 16'h0, 1);
        chk("level_pop_pair", 32'(level), 32'd1);
`else
        chk("pair_ext", 32'(instr_ext), 32'h0000);
        step(1'b1, 1'b0, 16'h0, 1);
        chk("level_pop_a", 32'(level), 32'd2);
        chk("ext_word_alone", 32'(instr), 32'h00AA);
        chk("ext_word_ext", 32'(instr_ext), 32'h0000);
        step(1'b1, 1'b0, 16'h0, 1);
        chk("level_pop_b", 32'(level), 32'd1);
`endif

        // Redirect while a 3-wait-state request is outstanding
        do_reset();
        step(1'b0, 1'b0, 16'h0, 3);
        chk("req_before_br", 32'(mem_req), 32'd1);
        step(1'b0, 1'b1, 16'h0041, 3);
        chk("drop_req", 32'(mem_req), 32'd1);
        chk("drop_addr", 32'(mem_addr), 32'h0000);
        chk("drop_level", 32'(level), 32'd0);
        step(1'b0, 1'b0, 16'h0, 3);
        step(1'b0, 1'b0, 16'h0, 3);
        chk("drop_addr_hold", 32'(mem_addr), 32'h0000);
        step(1'b0, 1'b0, 16'h0, 3);
        chk("target_req", 32'(mem_req), 32'd1);
        chk("target_addr", 32'(mem_addr), 32'h0040);
        for (int i = 0; i < 30 && !instr_valid; i++) step(1'b0, 1'b0, 16'h0, 0);
        chk("first_pc_after_br", 32'(instr_pc), 32'h0040);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0, 0);

        // Address wrap 0xFFFE -> 0x0000 -> 0x0002
        step(1'b0, 1'b1, 16'hFFFE, 0);
        chk("wrap_addr0", 32'(mem_addr), 32'hFFFE);
        step(1'b0, 1'b0, 16'h0, 0);
        chk("wrap_addr1", 32'(mem_addr), 32'h0000);
        step(1'b0, 1'b0, 16'h0, 0);
        chk("wrap_addr2", 32'(mem_addr), 32'h0002);
        for (int i = 0; i < 30 && !instr_valid; i++) step(1'b0, 1'b0, 16'h0, 0);
        chk("wrap_pc", 32'(instr_pc), 32'hFFFE);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0, 0);

        // Randomized run
        pops_start = pops;
        for (int i = 0; i < 10000; i++) begin
            bit rd, br;
            rd = (((i / 200) % 3) == 0) ? 1'b0 : ($urandom_range(0, 99) < 60);
            br = ($urandom_range(0, 99) < 2);
            step(rd, br, 16'($urandom), 2);
        end
        chk("random_progress", 32'((pops - pops_start) > 500), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
